// File: rtl/status_flags_pkg.sv
// -----------------------------------------------------------------------------
// status_flags_pkg
// Shared definitions for the 6502 status register / interrupt arbiter:
//   - FLAG_* : bit positions of the flags inside P (N V 1 B D I Z C)
//   - flag_cmd_t  : explicit set/clear flag instructions
//   - br_cond_t   : conditional branch opcodes in 6502 opcode order
//   - int_state_t : interrupt entry sequencer states
//   - fix_p()     : forces the two non-storage bits of P (bit5=1, bit4=0)
// -----------------------------------------------------------------------------
package status_flags_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_U = 5;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    typedef enum logic [2:0] {
        CMD_NONE, CMD_SEC, CMD_CLC, CMD_SEI, CMD_CLI, CMD_SED, CMD_CLD, CMD_CLV
    } flag_cmd_t;

    typedef enum logic [2:0] {
        BR_BPL, BR_BMI, BR_BVC, BR_BVS, BR_BCC, BR_BCS, BR_BNE, BR_BEQ
    } br_cond_t;

    typedef enum logic [1:0] {
        INT_IDLE, INT_PEND, INT_SERVICE
    } int_state_t;

    // B and bit5 have no storage in the real register: bit5 reads as 1 and
    // B only exists in the pushed copy, so the stored value keeps it at 0.
    function automatic logic [7:0] fix_p(input logic [7:0] p);
        logic [7:0] r;
        r         = p;
        r[FLAG_U] = 1'b1;
        r[FLAG_B] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/status_flags_if.sv
// -----------------------------------------------------------------------------
// status_flags_if
// Bundle between the control unit / ALU (master) and status_flags (slave).
//   ALU side     : alu_cout, alu_overflow, alu_zero, alu_negative -> ; <- alu_cin
//   flag control : flag_upd, flag_cmd, bit_op, operand, p_load, p_load_data
//   branch       : br_cond -> ; <- branch_taken
//   stack        : push_brk -> ; <- p_out, p_push
//   interrupts   : int_ack, int_done -> ; <- int_pending, int_is_nmi
// -----------------------------------------------------------------------------
interface status_flags_if;
    import status_flags_pkg::*;

    logic       alu_cout;
    logic       alu_overflow;
    logic       alu_zero;
    logic       alu_negative;
    logic [3:0] flag_upd;       // {N,V,Z,C} write enables
    flag_cmd_t  flag_cmd;
    logic       bit_op;
    logic [7:0] operand;
    logic       p_load;
    logic [7:0] p_load_data;
    br_cond_t   br_cond;
    logic       branch_taken;
    logic       alu_cin;
    logic [7:0] p_out;
    logic       push_brk;
    logic [7:0] p_push;
    logic       int_pending;
    logic       int_is_nmi;
    logic       int_ack;
    logic       int_done;

    modport master (
        output alu_cout, alu_overflow, alu_zero, alu_negative, flag_upd, flag_cmd,
               bit_op, operand, p_load, p_load_data, br_cond, push_brk, int_ack, int_done,
        input  branch_taken, alu_cin, p_out, p_push, int_pending, int_is_nmi
    );

    modport slave (
        input  alu_cout, alu_overflow, alu_zero, alu_negative, flag_upd, flag_cmd,
               bit_op, operand, p_load, p_load_data, br_cond, push_brk, int_ack, int_done,
        output branch_taken, alu_cin, p_out, p_push, int_pending, int_is_nmi
    );

endinterface

// File: rtl/status_flags_int_sync_edge.sv
// -----------------------------------------------------------------------------
// int_sync_edge
// Synchroniser for an asynchronous active-low interrupt pin, followed either
// by a falling-edge detector (EDGE=1, req is a one-cycle pulse) or by a plain
// level output (EDGE=0, req = synchronised pin is low).
//   clk    in  clock
//   rst_n  in  synchronous active-low reset (flops reset to the idle level 1)
//   pin_n  in  asynchronous active-low pin
//   req    out request (edge pulse or level, see EDGE)
// STAGES: number of synchroniser flops, 1..3.
// -----------------------------------------------------------------------------
module int_sync_edge #(
    parameter int STAGES = 2,
    parameter bit EDGE   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_n,
    output logic req
);

    logic [STAGES-1:0] sync_q;

    // NOTE: flops use non-blocking assignments so every stage samples the
    // value its predecessor held before this edge, giving a true shift chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= pin_n;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    generate
        if (EDGE) begin : g_edge
            logic prev_q;
            always_ff @(posedge clk) begin
                if (!rst_n) prev_q <= 1'b1;
                else        prev_q <= sync_q[STAGES-1];
            end
            assign req = prev_q & ~sync_q[STAGES-1];
        end else begin : g_level
            assign req = ~sync_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/status_flags.sv
// -----------------------------------------------------------------------------
// status_flags
// 6502 processor status register P (N V 1 B D I Z C) plus IRQ/NMI arbiter.
//   clk    in  clock, all state on rising edge
//   rst_n  in  synchronous active-low reset
//   nmi_n  in  asynchronous NMI pin, falling-edge triggered
//   irq_n  in  asynchronous IRQ pin, level, active low
//   bus    status_flags_if.slave: ALU flags, flag control, branch, stack
//          image and interrupt handshake (see status_flags_if)
// Build option: STATUS_CMOS_EN - when defined, interrupt/BRK entry (int_ack)
// also clears D as on the 65C02; otherwise D is left untouched (NMOS).
// -----------------------------------------------------------------------------
module status_flags
    import status_flags_pkg::*;
#(
    parameter logic [7:0] RESET_P     = 8'h24,
    parameter int         SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          nmi_n,
    input  logic          irq_n,
    status_flags_if.slave bus
);

    logic [7:0] p_q, p_d;
    int_state_t state_q, state_d;
    logic       nmi_latch_q, nmi_latch_d;
    logic       is_nmi_q, is_nmi_d;     // vector choice frozen for SERVICE
    logic       nmi_fall, irq_level, irq_req, any_req;

    int_sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_nmi_sync (
        .clk(clk), .rst_n(rst_n), .pin_n(nmi_n), .req(nmi_fall)
    );

    int_sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_irq_sync (
        .clk(clk), .rst_n(rst_n), .pin_n(irq_n), .req(irq_level)
    );

    // IRQ is not latched: it only counts while the pin is low and I is clear.
    assign irq_req = irq_level & ~p_q[FLAG_I];
    assign any_req = nmi_latch_q | irq_req;

    // P next value: load > BIT > flag command > masked ALU update.
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        p_d = p_q;
        if (bus.p_load) begin
            p_d = bus.p_load_data;
        end else if (bus.bit_op) begin
            p_d = (p_q & 8'h3D) | (bus.operand & 8'hC0) | {6'b0, bus.alu_zero, 1'b0};
        end else if (bus.flag_cmd != CMD_NONE) begin
            case (bus.flag_cmd)
                CMD_SEC: p_d[FLAG_C] = 1'b1;
                CMD_CLC: p_d[FLAG_C] = 1'b0;
                CMD_SEI: p_d[FLAG_I] = 1'b1;
                CMD_CLI: p_d[FLAG_I] = 1'b0;
                CMD_SED: p_d[FLAG_D] = 1'b1;
                CMD_CLD: p_d[FLAG_D] = 1'b0;
                CMD_CLV: p_d[FLAG_V] = 1'b0;
                default: ;
            endcase
        end else begin
            if (bus.flag_upd[3]) p_d[FLAG_N] = bus.alu_negative;
            if (bus.flag_upd[2]) p_d[FLAG_V] = bus.alu_overflow;
            if (bus.flag_upd[1]) p_d[FLAG_Z] = bus.alu_zero;
            if (bus.flag_upd[0]) p_d[FLAG_C] = bus.alu_cout;
        end
        // Entry sequence masks further IRQs regardless of what else happens.
        if (bus.int_ack) begin
            p_d[FLAG_I] = 1'b1;
`ifdef STATUS_CMOS_EN
            p_d[FLAG_D] = 1'b0;
`endif
        end
        p_d = fix_p(p_d);
    end

    // Interrupt sequencer next state.
    always_comb begin
        state_d     = state_q;
        nmi_latch_d = nmi_latch_q;
        is_nmi_d    = is_nmi_q;
        unique case (state_q)
            INT_IDLE: begin
                if (any_req) state_d = INT_PEND;
            end
            INT_PEND: begin
                // An acknowledge commits the control unit, so it wins over a
                // request withdrawn in the same cycle.
                if (bus.int_ack) begin
                    state_d     = INT_SERVICE;
                    is_nmi_d    = nmi_latch_q;
                    nmi_latch_d = 1'b0;
                end else if (!any_req) begin
                    state_d = INT_IDLE;
                end
            end
            INT_SERVICE: begin
                if (bus.int_done) state_d = INT_IDLE;
            end
            default: state_d = INT_IDLE;
        endcase
        // A fresh edge always survives, even in the acknowledging cycle.
        if (nmi_fall) nmi_latch_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q         <= RESET_P;
            state_q     <= INT_IDLE;
            nmi_latch_q <= 1'b0;
            is_nmi_q    <= 1'b0;
        end else begin
            p_q         <= p_d;
            state_q     <= state_d;
            nmi_latch_q <= nmi_latch_d;
            is_nmi_q    <= is_nmi_d;
        end
    end

    // Branch evaluation from the registered P.
    always_comb begin
        bus.branch_taken = 1'b0;
        case (bus.br_cond)
            BR_BPL: bus.branch_taken = ~p_q[FLAG_N];
            BR_BMI: bus.branch_taken =  p_q[FLAG_N];
            BR_BVC: bus.branch_taken = ~p_q[FLAG_V];
            BR_BVS: bus.branch_taken =  p_q[FLAG_V];
            BR_BCC: bus.branch_taken = ~p_q[FLAG_C];
            BR_BCS: bus.branch_taken =  p_q[FLAG_C];
            BR_BNE: bus.branch_taken = ~p_q[FLAG_Z];
            BR_BEQ: bus.branch_taken =  p_q[FLAG_Z];
            default: bus.branch_taken = 1'b0;
        endcase
    end

    assign bus.alu_cin     = p_q[FLAG_C];
    assign bus.p_out       = p_q;
    assign bus.p_push      = {p_q[7:6], 1'b1, bus.push_brk, p_q[3:0]};
    assign bus.int_pending = (state_q == INT_PEND);
    // NMI has priority while pending; the choice is frozen once acknowledged.
    assign bus.int_is_nmi  = (state_q == INT_PEND)    ? nmi_latch_q :
                             (state_q == INT_SERVICE) ? is_nmi_q    : 1'b0;

endmodule

// File: tb/tb_status_flags.sv
// -----------------------------------------------------------------------------
// tb_status_flags
// Self-checking bench for status_flags: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of P and of
// the interrupt protocol. Honours STATUS_CMOS_EN when the RTL is built with it.
// -----------------------------------------------------------------------------
module tb_status_flags;
    import status_flags_pkg::*;

    localparam int         S  = 2;
    localparam logic [7:0] RP = 8'h24;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic nmi_n = 1'b1;
    logic irq_n = 1'b1;

    always #5 clk = ~clk;

    status_flags_if bus ();

    status_flags #(.RESET_P(RP), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .nmi_n(nmi_n), .irq_n(irq_n), .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_p;
    bit         m_nmi_flag, m_pend, m_svc, m_svc_nmi;
    bit         nh[$];          // nmi_n samples, index 0 = most recent edge
    bit         ih[$];          // irq_n samples

    task automatic model_reset();
        m_p        = RP;
        m_nmi_flag = 0;
        m_pend     = 0;
        m_svc      = 0;
        m_svc_nmi  = 0;
        nh.delete();
        ih.delete();
        for (int i = 0; i <= S; i++) begin
            nh.push_back(1'b1);
            ih.push_back(1'b1);
        end
    endtask

    function automatic bit br_model(input logic [2:0] c, input logic [7:0] p);
        int idx;
        case (c[2:1])
            2'd0:    idx = 7;   // N
            2'd1:    idx = 6;   // V
            2'd2:    idx = 0;   // C
            default: idx = 1;   // Z
        endcase
        return p[idx] == c[0];
    endfunction

    task automatic model_step();
        bit         fall, req;
        logic [7:0] np;
        int         bit_idx;
        bit         bit_val;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // the pin as seen S edges ago, and the one before, define the edge
        fall = nh[S] & ~nh[S-1];
        req  = m_nmi_flag | (~ih[S-1] & ~m_p[2]);

        if (m_pend) begin
            if (bus.int_ack) begin
                m_pend     = 0;
                m_svc      = 1;
                m_svc_nmi  = m_nmi_flag;
                m_nmi_flag = 0;
            end else if (!req) begin
                m_pend = 0;
            end
        end else if (m_svc) begin
            if (bus.int_done) m_svc = 0;
        end else if (req) begin
            m_pend = 1;
        end
        if (fall) m_nmi_flag = 1;

        np = m_p;
        if (bus.p_load) begin
            np = bus.p_load_data;
        end else if (bus.bit_op) begin
            np[7] = bus.operand[7];
            np[6] = bus.operand[6];
            np[1] = bus.alu_zero;
        end else if (bus.flag_cmd != CMD_NONE) begin
            case (bus.flag_cmd)
                CMD_SEC: begin bit_idx = 0; bit_val = 1; end
                CMD_CLC: begin bit_idx = 0; bit_val = 0; end
                CMD_SEI: begin bit_idx = 2; bit_val = 1; end
                CMD_CLI: begin bit_idx = 2; bit_val = 0; end
                CMD_SED: begin bit_idx = 3; bit_val = 1; end
                CMD_CLD: begin bit_idx = 3; bit_val = 0; end
                default: begin bit_idx = 6; bit_val = 0; end
            endcase
            np[bit_idx] = bit_val;
        end else begin
            if (bus.flag_upd[0]) np[0] = bus.alu_cout;
            if (bus.flag_upd[1]) np[1] = bus.alu_zero;
            if (bus.flag_upd[2]) np[6] = bus.alu_overflow;
            if (bus.flag_upd[3]) np[7] = bus.alu_negative;
        end
        if (bus.int_ack) begin
            np[2] = 1'b1;
`ifdef STATUS_CMOS_EN
            np[3] = 1'b0;
`endif
        end
        m_p = (np | 8'h20) & 8'hEF;

        nh.push_front(nmi_n);
        void'(nh.pop_back());
        ih.push_front(irq_n);
        void'(ih.pop_back());
    endtask

    task automatic compare_all();
        check("p_out",        bus.p_out,        m_p);
        check("alu_cin",      bus.alu_cin,      m_p[0]);
        check("p_push",       bus.p_push,       {m_p[7:6], 1'b1, bus.push_brk, m_p[3:0]});
        check("branch_taken", bus.branch_taken, br_model(bus.br_cond, m_p));
        check("int_pending",  bus.int_pending,  m_pend);
        check("int_is_nmi",   bus.int_is_nmi,   m_pend ? m_nmi_flag : (m_svc ? m_svc_nmi : 1'b0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        bus.alu_cout     = 0;
        bus.alu_overflow = 0;
        bus.alu_zero     = 0;
        bus.alu_negative = 0;
        bus.flag_upd     = 4'b0;
        bus.flag_cmd     = CMD_NONE;
        bus.bit_op       = 0;
        bus.operand      = 8'h00;
        bus.p_load       = 0;
        bus.p_load_data  = 8'h00;
        bus.br_cond      = BR_BPL;
        bus.push_brk     = 0;
        bus.int_ack      = 0;
        bus.int_done     = 0;
    endtask

    task automatic wait_for(input string tag, input bit want_nmi, input int budget);
        int n = 0;
        while (!(bus.int_pending && bus.int_is_nmi == want_nmi) && n < budget) begin
            tick();
            n++;
        end
        check(tag, bus.int_pending && bus.int_is_nmi == want_nmi, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_reset();

        // 1. reset then idle
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
        check("rst_p_out",   bus.p_out,       8'h24);
        check("rst_alu_cin", bus.alu_cin,     1'b0);
        check("rst_pending", bus.int_pending, 1'b0);

        // 2. full ALU update
        bus.flag_upd = 4'b1111;
        {bus.alu_cout, bus.alu_overflow, bus.alu_zero, bus.alu_negative} = 4'b1101;
        tick();
        idle_inputs();
        check("alu_upd", bus.p_out, 8'hE5);

        // 3. load beats flag command, bit4 stored 0
        bus.p_load      = 1;
        bus.p_load_data = 8'hFF;
        bus.flag_cmd    = CMD_CLC;
        tick();
        idle_inputs();
        check("load_prio", bus.p_out, 8'hEF);

        // 4. IRQ latency, ack sets I, no re-entry afterwards
        bus.flag_cmd = CMD_CLI;
        tick();
        idle_inputs();
        irq_n = 0;
        tick();
        tick();
        check("irq_lat_early", bus.int_pending, 1'b0);
        tick();
        check("irq_lat",    bus.int_pending, 1'b1);
        check("irq_is_nmi", bus.int_is_nmi,  1'b0);
        bus.int_ack = 1;
        tick();
        bus.int_ack = 0;
        check("irq_ack_i",   bus.p_out[2],    1'b1);
        check("irq_svc_pnd", bus.int_pending, 1'b0);
        tick();
        bus.int_done = 1;
        tick();
        bus.int_done = 0;
        for (int i = 0; i < 4; i++) tick();
        check("irq_masked", bus.int_pending, 1'b0);
        irq_n = 1;

        // 5. NMI overtakes a pending IRQ; second NMI during SERVICE
        bus.flag_cmd = CMD_CLI;
        tick();
        idle_inputs();
        irq_n = 0;
        wait_for("irq_pend", 1'b0, 8);
        nmi_n = 0;
        wait_for("nmi_over_irq", 1'b1, 8);
        bus.int_ack = 1;
        tick();
        bus.int_ack = 0;
        irq_n = 1;
        nmi_n = 1;
        check("nmi_svc_vec", bus.int_is_nmi, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        nmi_n = 0;
        for (int i = 0; i < 4; i++) tick();
        check("nmi_in_svc", bus.int_pending, 1'b0);
        bus.int_done = 1;
        tick();
        bus.int_done = 0;
        check("nmi_done_idle", bus.int_pending, 1'b0);
        tick();
        check("nmi_reentry", bus.int_pending, 1'b1);
        check("nmi_reentry_vec", bus.int_is_nmi, 1'b1);
        bus.int_ack = 1;
        tick();
        bus.int_ack = 0;
        bus.int_done = 1;
        tick();
        bus.int_done = 0;
        nmi_n = 1;
        for (int i = 0; i < 4; i++) tick();

        // NMI latency from IDLE: SYNC_STAGES+2 edges
        nmi_n = 0;
        for (int i = 0; i < S + 1; i++) tick();
        check("nmi_lat_early", bus.int_pending, 1'b0);
        tick();
        check("nmi_lat", bus.int_pending, 1'b1);
        bus.int_ack = 1;
        tick();
        bus.int_ack = 0;
        bus.int_done = 1;
        tick();
        bus.int_done = 0;
        nmi_n = 1;
        for (int i = 0; i < 4; i++) tick();

        // 6. BIT and branch evaluation
        bus.bit_op   = 1;
        bus.operand  = 8'hC0;
        bus.alu_zero = 1;
        tick();
        idle_inputs();
        check("bit_n", bus.p_out[7], 1'b1);
        check("bit_v", bus.p_out[6], 1'b1);
        check("bit_z", bus.p_out[1], 1'b1);
        bus.br_cond = BR_BEQ; #1 check("br_beq", bus.branch_taken, 1'b1);
        bus.br_cond = BR_BMI; #1 check("br_bmi", bus.branch_taken, 1'b1);
        bus.br_cond = BR_BVS; #1 check("br_bvs", bus.branch_taken, 1'b1);
        bus.br_cond = BR_BNE; #1 check("br_bne", bus.branch_taken, 1'b0);

        // randomized traffic against the model
        for (int cyc = 0; cyc < 2000; cyc++) begin
            idle_inputs();
            rst_n = ($urandom_range(0, 299) != 0);
            {bus.alu_cout, bus.alu_overflow, bus.alu_zero, bus.alu_negative} = 4'($urandom);
            bus.flag_upd    = 4'($urandom);
            bus.operand     = 8'($urandom);
            bus.p_load_data = 8'($urandom);
            bus.br_cond     = br_cond_t'($urandom_range(0, 7));
            bus.push_brk    = 1'($urandom);
            bus.p_load      = ($urandom_range(0, 15) == 0);
            bus.bit_op      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) bus.flag_cmd = flag_cmd_t'($urandom_range(1, 7));
            bus.int_ack     = ($urandom_range(0, 5) == 0);
            bus.int_done    = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) nmi_n = ~nmi_n;
            if ($urandom_range(0, 9) == 0) irq_n = ~irq_n;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
